// File: rtl/prog_pkg.sv
// Purpose: shared types, defaults and helpers for the programming sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package prog_pkg;

    localparam int DEF_N_COLS = 7;
    localparam int DEF_N_ROWS = 7;

    typedef enum logic [1:0] {
        OP_INJECT = 2'b00,
        OP_TUNNEL = 2'b01,
        OP_READ   = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_PULSE_ON,
        S_PULSE_OFF,
        S_READ,
        S_DONE
    } state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // A command is rejected up front when it addresses a cell outside the
    // island, uses the reserved opcode, or asks for zero programming pulses.
    function automatic logic cmd_legal(input logic [2:0] col, input logic [2:0] row,
                                       input logic [1:0] op, input logic [7:0] pulses,
                                       input int n_cols, input int n_rows);
        logic pulsed;
        pulsed = (op == OP_INJECT) || (op == OP_TUNNEL);
        return (int'(col) < n_cols) && (int'(row) < n_rows) &&
               (op != OP_RSVD) && !(pulsed && (pulses == 8'd0));
    endfunction

endpackage

// File: rtl/prog_timer.sv
// Purpose: loadable down-counter with zero flag, shared by every timed phase.
// Latency: value visible the cycle after load; counts down one per cycle, holds at 0.
// Backpressure: none; load always wins over counting.
// Ports: clk, rst_n (sync, active-low), load/load_val (new count), zero (count == 0).
module prog_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/prog_seq.sv
// Purpose: sequences inject/tunnel pulse trains and read windows onto the CAB programming mux.
// Latency: response SETTLE_CYC + phase time + 1 cycles after accept; 1 cycle for rejected commands.
// Backpressure: cmd_ready high only in IDLE; one command in flight, abort forces early completion.
// Ports: clk, rst_n; cmd_* request with valid/ready; abort; adc_data readout;
//        col_sel/row_sel mux select; inj_en/tun_en/rd_en drive enables; rsp_* completion.
module prog_seq
    import prog_pkg::*;
#(
    parameter int N_COLS     = DEF_N_COLS,
    parameter int N_ROWS     = DEF_N_ROWS,
    parameter int SETTLE_CYC = 8,
    parameter int ON_CYC     = 16,
    parameter int OFF_CYC    = 4,
    parameter int READ_CYC   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_col,
    input  logic [2:0] cmd_row,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_pulses,
    input  logic       abort,
    input  logic [9:0] adc_data,
    output logic [2:0] col_sel,
    output logic [2:0] row_sel,
    output logic       inj_en,
    output logic       tun_en,
    output logic       rd_en,
    output logic       rsp_valid,
    output logic       rsp_err,
    output logic [9:0] rsp_data
);

    localparam int MAX_CYC = max4(SETTLE_CYC, ON_CYC, OFF_CYC, READ_CYC);
    localparam int CW      = $clog2(MAX_CYC + 1);

    // The timer is loaded with (phase length - 1) on the edge that enters a
    // phase, so the phase ends on the cycle the zero flag is seen.
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] ON_LD     = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LD    = CW'(OFF_CYC - 1);
    localparam logic [CW-1:0] READ_LD   = CW'(READ_CYC - 1);

    state_e        state;
    op_e           op_q;
    logic [7:0]    pulses_left;
    logic          accept;
    logic          legal;
    logic          abort_hit;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;

    assign accept = cmd_valid && cmd_ready;
    assign legal  = cmd_legal(cmd_col, cmd_row, cmd_op, cmd_pulses, N_COLS, N_ROWS);
    // DONE is already reporting, so an abort there would only duplicate the response.
    assign abort_hit = abort && (state != S_IDLE) && (state != S_DONE);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (!abort_hit) begin
            case (state)
                S_IDLE: begin
                    if (accept && legal) begin
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_LD;
                    end
                end
                S_SETTLE: begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        tmr_val  = (op_q == OP_READ) ? READ_LD : ON_LD;
                    end
                end
                S_PULSE_ON: begin
                    if (tmr_zero && (pulses_left > 8'd1)) begin
                        tmr_load = 1'b1;
                        tmr_val  = OFF_LD;
                    end
                end
                S_PULSE_OFF: begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        tmr_val  = ON_LD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    prog_timer #(
        .W (CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= OP_INJECT;
            pulses_left <= 8'd0;
            cmd_ready   <= 1'b0;
            col_sel     <= 3'd0;
            row_sel     <= 3'd0;
            inj_en      <= 1'b0;
            tun_en      <= 1'b0;
            rd_en       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_data    <= 10'd0;
        end else begin
            rsp_valid <= 1'b0;
            if (abort_hit) begin
                inj_en    <= 1'b0;
                tun_en    <= 1'b0;
                rd_en     <= 1'b0;
                state     <= S_DONE;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_data  <= 10'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            cmd_ready   <= 1'b0;
                            op_q        <= op_e'(cmd_op);
                            pulses_left <= cmd_pulses;
                            if (legal) begin
                                col_sel <= cmd_col;
                                row_sel <= cmd_row;
                                state   <= S_SETTLE;
                            end else begin
                                // Rejected commands leave the mux select untouched.
                                state     <= S_DONE;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_data  <= 10'd0;
                            end
                        end else begin
                            cmd_ready <= 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (tmr_zero) begin
                            if (op_q == OP_READ) begin
                                state <= S_READ;
                                rd_en <= 1'b1;
                            end else begin
                                state  <= S_PULSE_ON;
                                inj_en <= (op_q == OP_INJECT);
                                tun_en <= (op_q == OP_TUNNEL);
                            end
                        end
                    end
                    S_PULSE_ON: begin
                        if (tmr_zero) begin
                            inj_en <= 1'b0;
                            tun_en <= 1'b0;
                            if (pulses_left != 8'd0) begin
                                pulses_left <= pulses_left - 8'd1;
                            end
                            if (pulses_left > 8'd1) begin
                                state <= S_PULSE_OFF;
                            end else begin
                                // Last pulse finishes straight into DONE, no trailing gap.
                                state     <= S_DONE;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b0;
                                rsp_data  <= 10'd0;
                            end
                        end
                    end
                    S_PULSE_OFF: begin
                        if (tmr_zero) begin
                            state  <= S_PULSE_ON;
                            inj_en <= (op_q == OP_INJECT);
                            tun_en <= (op_q == OP_TUNNEL);
                        end
                    end
                    S_READ: begin
                        if (tmr_zero) begin
                            rd_en     <= 1'b0;
                            state     <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= adc_data;
                        end
                    end
                    S_DONE: begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= 10'd0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/prog_seq.md
PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 Parameter N_COLS, default 7, CAB columns per island (col 0 = cab1, cols 1..6 = cab2).
REQ-002 Parameter N_ROWS, default 7, switch-matrix rows per CAB.
REQ-003 Parameter SETTLE_CYC, default 8, mux settle cycles before any pulse or read.
REQ-004 Parameter ON_CYC, default 16, cycles per programming pulse (enable high).
REQ-005 Parameter OFF_CYC, default 4, gap cycles between pulses (enable low).
REQ-006 Parameter READ_CYC, default 32, read window cycles.
REQ-007 clk  input  1  single clock; all logic rising-edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 cmd_valid  input  1  command offered.
REQ-010 cmd_ready  output  1  sequencer accepts command.
REQ-011 cmd_col  input  3  target CAB column.
REQ-012 cmd_row  input  3  target matrix row.
REQ-013 cmd_op  input  2  00 inject, 01 tunnel, 10 read, 11 reserved.
REQ-014 cmd_pulses  input  8  pulse count for inject/tunnel.
REQ-015 abort  input  1  terminate current command.
REQ-016 adc_data  input  10  fabric readout value.
REQ-017 col_sel  output  3  programming-mux column select.
REQ-018 row_sel  output  3  programming-mux row select.
REQ-019 inj_en / tun_en / rd_en  output  1 each  fabric drive enables.
REQ-020 rsp_valid  output  1  one-cycle completion strobe.
REQ-021 rsp_err  output  1  error qualifier, valid with rsp_valid.
REQ-022 rsp_data  output  10  read result, valid with rsp_valid.

Function
REQ-023 Handshake: command accepted on cycle where cmd_valid && cmd_ready; cmd_ready high only in IDLE.
REQ-024 States: IDLE, SETTLE, PULSE_ON, PULSE_OFF, READ, DONE.
REQ-025 Accept with legal command: latch fields, drive col_sel/row_sel next cycle, enter SETTLE for SETTLE_CYC cycles.
REQ-026 Illegal command (col>=N_COLS, row>=N_ROWS, op=11, or inject/tunnel with pulses=0): go directly to DONE, rsp_err=1, no enable ever asserted.
REQ-027 SETTLE exit: op 00/01 -> PULSE_ON; op 10 -> READ.
REQ-028 PULSE_ON: inj_en (op 00) or tun_en (op 01) high exactly ON_CYC cycles; then decrement remaining count.
REQ-029 Remaining count nonzero -> PULSE_OFF for OFF_CYC cycles then PULSE_ON; zero -> DONE (no trailing gap).
REQ-030 READ: rd_en high READ_CYC cycles; adc_data sampled on last READ cycle into rsp_data.
REQ-031 DONE: one cycle, rsp_valid=1, then IDLE; rsp_data=0 for non-read ops.
REQ-032 inj_en, tun_en, rd_en mutually exclusive at all times; never high outside PULSE_ON/READ.
REQ-033 col_sel/row_sel stable from SETTLE entry through DONE.
REQ-034 abort in any non-IDLE state: all enables low next cycle, enter DONE with rsp_err=1; abort in IDLE ignored; abort and accept same cycle: accept wins, abort ignored.
REQ-035 Cycle counter width ceil(log2(max(SETTLE_CYC,ON_CYC,OFF_CYC,READ_CYC)+1)); pulse counter 8 bits, no wrap.

Reset
REQ-036 rst_n low at clock edge: state IDLE, cmd_ready=0 during reset, 1 first cycle after release.
REQ-037 Reset values: col_sel=0, row_sel=0, all enables 0, rsp_valid=0, rsp_err=0, rsp_data=0, counters 0.
REQ-038 Reset mid-command: enables low on next edge; no rsp_valid issued for interrupted command.

Structure
REQ-039 Shared package prog_pkg holds op encoding enum, state enum, N_COLS/N_ROWS defaults.
REQ-040 One sub-module prog_timer (loadable down-counter with zero flag) reused for all phase timing.

Verification
REQ-041 Inject col 3 row 5 pulses 2 -> inj_en high 16, low 4, high 16; rsp_valid 8+36+1 cycles after accept, rsp_err=0.
REQ-042 Read col 0 row 0, adc_data=0x155 on last read cycle -> rd_en 32 cycles, rsp_data=0x155.
REQ-043 Command col 7 -> rsp_valid next cycle after accept, rsp_err=1, no enable asserted.
REQ-044 Tunnel pulses 3, abort during 2nd PULSE_ON -> tun_en low next cycle, rsp_err=1, cmd_ready high after DONE.
REQ-045 rst_n low mid-PULSE_ON -> all outputs at reset values next cycle, no rsp_valid.
REQ-046 Back-to-back valid commands -> second accepted only on IDLE cycle after DONE; one-hot enable assertion checked throughout.
